// File: rtl/gfx_line_sched_pkg.sv
// Shared types and constants for the gfx_line_sched command sequencer.
package gfx_line_sched_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StInit   = 2'd2,
        StDraw   = 2'd3
    } state_t;

    // Cycles the engine is given after start before pixels are consumed.
    localparam int unsigned INIT_CYCLES = 2;

    function automatic int addr_bits(input int width, input int height);
        return $clog2(width * height);
    endfunction

endpackage

// File: rtl/gfx_line.sv
// Bresenham line engine: loads endpoints on start, then emits one pixel per enabled cycle,
// always walking from the endpoint with the smaller y towards the larger one.
module gfx_line #(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    input  logic [X_BITS-1:0] x0,
    input  logic [Y_BITS-1:0] y0,
    input  logic [X_BITS-1:0] x1,
    input  logic [Y_BITS-1:0] y1,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              done
);
    localparam int E_BITS = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 3;

    logic [X_BITS-1:0]        xs, xe, dx_n, x_end_q, dx_q, x_d;
    logic [Y_BITS-1:0]        ys, ye, dy_n, y_end_q, dy_q, y_d;
    logic                     x_neg_n, x_neg_q;
    logic signed [E_BITS-1:0] err_q, err_d, e2, dx_s, dy_s;

    always_comb begin
        xs = x0;
        ys = y0;
        xe = x1;
        ye = y1;
        if (y0 > y1) begin
            xs = x1;
            ys = y1;
            xe = x0;
            ye = y0;
        end
        x_neg_n = (xe < xs);
        dx_n    = x_neg_n ? (xs - xe) : (xe - xs);
        dy_n    = ye - ys;
    end

    assign dx_s = signed'(E_BITS'(dx_q));
    assign dy_s = signed'(E_BITS'(dy_q));
    assign e2   = err_q <<< 1;
    assign done = (x == x_end_q) && (y == y_end_q);

    // Both axis decisions use the same e2 so diagonal steps happen in one cycle.
    always_comb begin
        err_d = err_q;
        x_d   = x;
        y_d   = y;
        if (e2 >= -dy_s) begin
            err_d = err_d - dy_s;
            x_d   = x_neg_q ? (x - X_BITS'(1)) : (x + X_BITS'(1));
        end
        if (e2 <= dx_s) begin
            err_d = err_d + dx_s;
            y_d   = y + Y_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            x_neg_q <= 1'b0;
            err_q   <= '0;
        end else if (start) begin
            x       <= xs;
            y       <= ys;
            x_end_q <= xe;
            y_end_q <= ye;
            dx_q    <= dx_n;
            dy_q    <= dy_n;
            x_neg_q <= x_neg_n;
            err_q   <= signed'(E_BITS'(dx_n)) - signed'(E_BITS'(dy_n));
        end else if (enable && !done) begin
            x     <= x_d;
            y     <= y_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/gfx_line_sched.sv
// Command sequencer around gfx_line: accepts line commands, streams pixels with address/color.
// Optional stat_lines/stat_pixels counters are built when GFX_LINE_SCHED_STATS_EN is defined.
module gfx_line_sched
    import gfx_line_sched_pkg::*;
#(
    parameter  int FB_WIDTH   = 640,
    parameter  int FB_HEIGHT  = 480,
    parameter  int COLOR_BITS = 12,
    localparam int FB_X_BITS  = $clog2(FB_WIDTH),
    localparam int FB_Y_BITS  = $clog2(FB_HEIGHT),
    localparam int ADDR_BITS  = addr_bits(FB_WIDTH, FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FB_X_BITS-1:0]  cmd_x0,
    input  logic [FB_Y_BITS-1:0]  cmd_y0,
    input  logic [FB_X_BITS-1:0]  cmd_x1,
    input  logic [FB_Y_BITS-1:0]  cmd_y1,
    input  logic [COLOR_BITS-1:0] cmd_color,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [FB_X_BITS-1:0]  pix_x,
    output logic [FB_Y_BITS-1:0]  pix_y,
    output logic [ADDR_BITS-1:0]  pix_addr,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic                  busy,
    output logic                  line_done
`ifdef GFX_LINE_SCHED_STATS_EN
    ,
    output logic [15:0]           stat_lines,
    output logic [31:0]           stat_pixels
`endif
);
    state_t                 state;
    logic [1:0]             init_cnt;
    logic                   eng_start;
    logic                   eng_enable;
    logic                   eng_done;
    logic                   at_end;
    logic [FB_X_BITS-1:0]   x0_q, x1_q, end_x_q;
    logic [FB_Y_BITS-1:0]   y0_q, y1_q, end_y_q;

    assign at_end     = (pix_x == end_x_q) && (pix_y == end_y_q);
    assign eng_enable = (state == StDraw) && pix_ready;
    assign pix_addr   = ADDR_BITS'(pix_y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(pix_x);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cmd_ready <= 1'b1;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            line_done <= 1'b0;
            eng_start <= 1'b0;
            init_cnt  <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            end_x_q   <= '0;
            end_y_q   <= '0;
            pix_color <= '0;
        end else begin
            line_done <= 1'b0;
            eng_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        x0_q      <= cmd_x0;
                        y0_q      <= cmd_y0;
                        x1_q      <= cmd_x1;
                        y1_q      <= cmd_y1;
                        pix_color <= cmd_color;
                        // The engine walks top-to-bottom, so the last pixel has the larger y.
                        end_x_q   <= (cmd_y0 > cmd_y1) ? cmd_x0 : cmd_x1;
                        end_y_q   <= (cmd_y0 > cmd_y1) ? cmd_y0 : cmd_y1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        eng_start <= 1'b1;
                        state     <= StLaunch;
                    end
                end
                StLaunch: begin
                    init_cnt <= '0;
                    state    <= StInit;
                end
                StInit: begin
                    if (init_cnt == 2'(INIT_CYCLES - 1)) begin
                        pix_valid <= 1'b1;
                        state     <= StDraw;
                    end else begin
                        init_cnt <= init_cnt + 2'd1;
                    end
                end
                StDraw: begin
                    if (pix_ready && at_end) begin
                        pix_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        line_done <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    gfx_line #(
        .X_BITS(FB_X_BITS),
        .Y_BITS(FB_Y_BITS)
    ) u_line (
        .clk   (clk),
        .reset (reset),
        .start (eng_start),
        .enable(eng_enable),
        .x0    (x0_q),
        .y0    (y0_q),
        .x1    (x1_q),
        .y1    (y1_q),
        .x     (pix_x),
        .y     (pix_y),
        .done  (eng_done)
    );

    // Sequencing relies on the latched end point; the engine must agree when we get there.
    a_end_matches_engine: assert property (@(posedge clk) disable iff (reset)
        (state == StDraw && at_end) |-> eng_done);

`ifdef GFX_LINE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_lines  <= '0;
            stat_pixels <= '0;
        end else begin
            if (line_done) begin
                stat_lines <= stat_lines + 16'd1;
            end
            if (pix_valid && pix_ready) begin
                stat_pixels <= stat_pixels + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gfx_line_sched.sv
// Self-checking bench for gfx_line_sched: directed cases plus randomized lines checked
// against geometric line properties (endpoints, pixel count, step shape, half-pixel error).
module tb_gfx_line_sched;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam int CB = 12;
    localparam int XB = 10;
    localparam int YB = 9;
    localparam int AB = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [XB-1:0] cmd_x0, cmd_x1;
    logic [YB-1:0] cmd_y0, cmd_y1;
    logic [CB-1:0] cmd_color;
    logic          pix_valid, pix_ready;
    logic [XB-1:0] pix_x;
    logic [YB-1:0] pix_y;
    logic [AB-1:0] pix_addr;
    logic [CB-1:0] pix_color;
    logic          busy, line_done;
`ifdef GFX_LINE_SCHED_STATS_EN
    logic [15:0]   stat_lines;
    logic [31:0]   stat_pixels;
`endif

    always #5 clk = ~clk;

    gfx_line_sched #(
        .FB_WIDTH  (W),
        .FB_HEIGHT (H),
        .COLOR_BITS(CB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_addr  (pix_addr),
        .pix_color (pix_color),
        .busy      (busy),
`ifdef GFX_LINE_SCHED_STATS_EN
        .stat_lines (stat_lines),
        .stat_pixels(stat_pixels),
`endif
        .line_done (line_done)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int got_x[$], got_y[$], got_a[$], got_c[$];
    int lat, done_gap, valid_at_done, ready_at_done, ready_busy_err, stall_err, timed_out;
    bit b2b_pending = 1'b0;
    int nx0, ny0, nx1, ny1, ncol;

    // Present a command and wait (at a negedge) until the next posedge will accept it.
    task automatic issue_cmd(input int x0, input int y0, input int x1, input int y1,
                             input int c);
        int n = 0;
        timed_out = 0;
        cmd_x0 = XB'(x0);
        cmd_y0 = YB'(y0);
        cmd_x1 = XB'(x1);
        cmd_y1 = YB'(y1);
        cmd_color = CB'(c);
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timed_out = 1;
    endtask

    // Collect one line's pixels after the accepting edge; mode 0: ready=1, 1: 1,0,0 pattern,
    // 2: random ready.
    task automatic collect_line(input int mode);
        int last_hs = 0;
        bit stalled = 1'b0;
        bit fin = 1'b0;
        bit pr;
        logic [XB+YB+AB+CB-1:0] hold = '0;
        got_x.delete(); got_y.delete(); got_a.delete(); got_c.delete();
        lat = -1; done_gap = -1; valid_at_done = -1; ready_at_done = -1;
        ready_busy_err = 0; stall_err = 0;
        for (int cyc = 1; cyc <= 5000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (b2b_pending) begin
                    cmd_x0 = XB'(nx0); cmd_y0 = YB'(ny0);
                    cmd_x1 = XB'(nx1); cmd_y1 = YB'(ny1);
                    cmd_color = CB'(ncol);
                    b2b_pending = 1'b0;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (line_done === 1'b1) begin
                done_gap = cyc - last_hs;
                valid_at_done = int'(pix_valid);
                ready_at_done = int'(cmd_ready);
                fin = 1'b1;
            end else begin
                if (cmd_ready !== 1'b0) ready_busy_err++;
                if (pix_valid === 1'b1) begin
                    if (lat < 0) lat = cyc;
                    if (stalled && {pix_x, pix_y, pix_addr, pix_color} !== hold) stall_err++;
                end
                case (mode)
                    0: pr = 1'b1;
                    1: pr = (cyc % 3 == 0);
                    default: pr = ($urandom_range(0, 3) != 0);
                endcase
                pix_ready = pr;
                if (pix_valid === 1'b1) begin
                    if (pr) begin
                        got_x.push_back(int'(pix_x));
                        got_y.push_back(int'(pix_y));
                        got_a.push_back(int'(pix_addr));
                        got_c.push_back(int'(pix_color));
                        last_hs = cyc;
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        hold = {pix_x, pix_y, pix_addr, pix_color};
                    end
                end
            end
        end
        if (!fin) timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0; pix_ready = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1) begin tests_failed++;
            $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        tests_run++;
        if (pix_valid !== 1'b0) begin tests_failed++;
            $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++;
            $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++;
        if (line_done !== 1'b0) begin tests_failed++;
            $display("FAIL reset_line_done got %b want 0", line_done); end
`ifdef GFX_LINE_SCHED_STATS_EN
        tests_run++;
        if (stat_lines !== 16'd0 || stat_pixels !== 32'd0) begin tests_failed++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", stat_lines, stat_pixels); end
`endif
    endtask

    task automatic test_horizontal();
        int bad = 0;
        issue_cmd(0, 0, 3, 0, 12'hABC);
        collect_line(0);
        tests_run++;
        if (timed_out !== 0) begin tests_failed++;
            $display("FAIL horiz_timeout got %0d want 0", timed_out); end
        tests_run++;
        if (lat !== 4) begin tests_failed++;
            $display("FAIL horiz_latency got %0d want 4", lat); end
        tests_run++;
        if (got_x.size() !== 4) begin tests_failed++;
            $display("FAIL horiz_count got %0d want 4", got_x.size()); end
        for (int i = 0; i < got_x.size(); i++)
            if (got_x[i] != i || got_y[i] != 0 || got_a[i] != i || got_c[i] != 'hABC) bad++;
        tests_run++;
        if (bad !== 0) begin tests_failed++;
            $display("FAIL horiz_pixels bad %0d want 0", bad); end
        tests_run++;
        if (done_gap !== 1 || valid_at_done !== 0) begin tests_failed++;
            $display("FAIL horiz_done gap %0d valid %0d want 1 0", done_gap, valid_at_done); end
    endtask

    task automatic test_vertical();
        int exp_a[4] = '{4485, 5125, 5765, 6405};
        int bad = 0;
        issue_cmd(5, 10, 5, 7, 12'h123);
        collect_line(0);
        tests_run++;
        if (got_x.size() !== 4 || timed_out !== 0) begin tests_failed++;
            $display("FAIL vert_count got %0d want 4", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < 4; i++)
            if (got_x[i] != 5 || got_y[i] != 7 + i || got_a[i] != exp_a[i]) bad++;
        tests_run++;
        if (bad !== 0) begin tests_failed++;
            $display("FAIL vert_pixels bad %0d want 0", bad); end
    endtask

    task automatic test_point();
        issue_cmd(2, 2, 2, 2, 12'hFFF);
        collect_line(0);
        tests_run++;
        if (got_x.size() !== 1 || timed_out !== 0) begin tests_failed++;
            $display("FAIL point_count got %0d want 1", got_x.size()); end
        tests_run++;
        if (got_a.size() > 0 && got_a[0] !== 1282) begin tests_failed++;
            $display("FAIL point_addr got %0d want 1282", got_a[0]); end
        tests_run++;
        if (ready_at_done !== 1 || done_gap !== 1) begin tests_failed++;
            $display("FAIL point_done ready %0d gap %0d want 1 1", ready_at_done, done_gap); end
    endtask

    task automatic test_stall();
        int rx[$], ry[$], ra[$];
        int bad = 0;
        issue_cmd(0, 0, 4, 2, 12'h5A5);
        collect_line(0);
        rx = got_x; ry = got_y; ra = got_a;
        issue_cmd(0, 0, 4, 2, 12'h5A5);
        collect_line(1);
        tests_run++;
        if (got_x.size() !== 5 || rx.size() !== 5) begin tests_failed++;
            $display("FAIL stall_count got %0d/%0d want 5", got_x.size(), rx.size()); end
        for (int i = 0; i < got_x.size() && i < rx.size(); i++)
            if (got_x[i] != rx[i] || got_y[i] != ry[i] || got_a[i] != ra[i]) bad++;
        tests_run++;
        if (bad !== 0) begin tests_failed++;
            $display("FAIL stall_sequence bad %0d want 0", bad); end
        tests_run++;
        if (stall_err !== 0 || timed_out !== 0) begin tests_failed++;
            $display("FAIL stall_stable changes %0d want 0", stall_err); end
        tests_run++;
        if (rx.size() > 0 && (rx[0] != 0 || ry[0] != 0 || rx[rx.size()-1] != 4
                              || ry[ry.size()-1] != 2)) begin tests_failed++;
            $display("FAIL stall_endpoints got (%0d,%0d) want (0,0)", rx[0], ry[0]); end
    endtask

    task automatic test_back_to_back();
        issue_cmd(1, 1, 6, 3, 12'h0F0);
        nx0 = 10; ny0 = 20; nx1 = 7; ny1 = 25; ncol = 12'h00F;
        b2b_pending = 1'b1;
        collect_line(0);
        tests_run++;
        if (ready_busy_err !== 0) begin tests_failed++;
            $display("FAIL b2b_ready_busy got %0d want 0", ready_busy_err); end
        tests_run++;
        if (ready_at_done !== 1 || got_x.size() !== 6) begin tests_failed++;
            $display("FAIL b2b_first ready %0d count %0d want 1 6", ready_at_done, got_x.size());
        end
        collect_line(0);
        tests_run++;
        if (lat !== 4 || timed_out !== 0) begin tests_failed++;
            $display("FAIL b2b_second_latency got %0d want 4", lat); end
        tests_run++;
        if (got_x.size() !== 6 || got_x[0] != 10 || got_y[0] != 20 || got_x[5] != 7
            || got_y[5] != 25 || got_c[0] != 'h00F) begin tests_failed++;
            $display("FAIL b2b_second_line count %0d want 6 from (10,20) to (7,25)",
                     got_x.size()); end
    endtask

    task automatic test_random();
        for (int l = 0; l < 25; l++) begin
            int x0, y0, x1, y1, c, xt, yt, xb, yb, dxs, dys, adx, n, mx;
            int bad_step = 0, bad_dev = 0, bad_pix = 0;
            if (l % 5 == 4) begin
                x0 = $urandom_range(0, W - 1); x1 = $urandom_range(0, W - 1);
                y0 = $urandom_range(0, H - 1); y1 = $urandom_range(0, H - 1);
            end else begin
                x0 = $urandom_range(0, 99); x1 = $urandom_range(0, 99);
                y0 = $urandom_range(0, 79); y1 = $urandom_range(0, 79);
            end
            c = $urandom_range(0, 4095);
            if (y0 > y1) begin xt = x1; yt = y1; xb = x0; yb = y0; end
            else begin xt = x0; yt = y0; xb = x1; yb = y1; end
            dxs = xb - xt; dys = yb - yt;
            adx = (dxs < 0) ? -dxs : dxs;
            mx = (adx > dys) ? adx : dys;
            n = mx + 1;
            issue_cmd(x0, y0, x1, y1, c);
            collect_line(2);
            tests_run++;
            if (timed_out !== 0 || lat !== 4) begin tests_failed++;
                $display("FAIL rand%0d_latency got %0d timeout %0d want 4", l, lat, timed_out);
            end
            tests_run++;
            if (got_x.size() !== n) begin tests_failed++;
                $display("FAIL rand%0d_count got %0d want %0d", l, got_x.size(), n); end
            tests_run++;
            if (got_x.size() == 0 || got_x[0] != xt || got_y[0] != yt
                || got_x[got_x.size()-1] != xb || got_y[got_y.size()-1] != yb) begin
                tests_failed++;
                $display("FAIL rand%0d_endpoints want (%0d,%0d)-(%0d,%0d)", l, xt, yt, xb, yb);
            end
            for (int i = 0; i < got_x.size(); i++) begin
                int v = 2 * ((got_x[i] - xt) * dys - dxs * (got_y[i] - yt));
                if (v < 0) v = -v;
                if (v > mx) bad_dev++;
                if (got_a[i] != got_y[i] * W + got_x[i] || got_c[i] != c) bad_pix++;
                if (i > 0) begin
                    int ddx = got_x[i] - got_x[i-1];
                    int ddy = got_y[i] - got_y[i-1];
                    if (ddx < -1 || ddx > 1 || ddy < 0 || ddy > 1 || (ddx == 0 && ddy == 0))
                        bad_step++;
                end
            end
            tests_run++;
            if (bad_step !== 0 || bad_dev !== 0) begin tests_failed++;
                $display("FAIL rand%0d_shape steps %0d dev %0d want 0 0", l, bad_step, bad_dev);
            end
            tests_run++;
            if (bad_pix !== 0) begin tests_failed++;
                $display("FAIL rand%0d_addr_color bad %0d want 0", l, bad_pix); end
            tests_run++;
            if (done_gap !== 1 || valid_at_done !== 0 || stall_err !== 0
                || ready_busy_err !== 0) begin tests_failed++;
                $display("FAIL rand%0d_handshake gap %0d valid %0d stall %0d rdy %0d want 1 0 0 0",
                         l, done_gap, valid_at_done, stall_err, ready_busy_err);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        int hs = 0;
        int bad = 0;
        issue_cmd(0, 5, 20, 5, 12'h777);
        pix_ready = 1'b1;
        for (int i = 0; i < 50 && hs < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (pix_valid === 1'b1) hs++;
        end
        tests_run++;
        if (hs !== 3) begin tests_failed++;
            $display("FAIL rst_mid_reach got %0d pixels want 3", hs); end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (pix_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || line_done !== 1'b0)
        begin tests_failed++;
            $display("FAIL rst_mid_outputs got v%b r%b b%b d%b want v0 r1 b0 d0",
                     pix_valid, cmd_ready, busy, line_done); end
`ifdef GFX_LINE_SCHED_STATS_EN
        tests_run++;
        if (stat_lines !== 16'd0 || stat_pixels !== 32'd0) begin tests_failed++;
            $display("FAIL rst_mid_stats got %0d/%0d want 0/0", stat_lines, stat_pixels); end
`endif
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (line_done !== 1'b0 || pix_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++;
            $display("FAIL rst_mid_quiet bad %0d want 0", bad); end
        issue_cmd(3, 3, 0, 0, 12'h321);
        collect_line(0);
        bad = 0;
        for (int i = 0; i < got_x.size(); i++)
            if (got_x[i] != i || got_y[i] != i || got_a[i] != i * W + i) bad++;
        tests_run++;
        if (got_x.size() !== 4 || bad !== 0 || timed_out !== 0) begin tests_failed++;
            $display("FAIL rst_mid_redraw count %0d bad %0d want 4 0", got_x.size(), bad); end
`ifdef GFX_LINE_SCHED_STATS_EN
        tests_run++;
        if (stat_lines !== 16'd1 || stat_pixels !== 32'd4) begin tests_failed++;
            $display("FAIL rst_mid_stats_after got %0d/%0d want 1/4", stat_lines, stat_pixels);
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_horizontal();
        test_vertical();
        test_point();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_draw();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
